length_bcd_converter: RTL and testbench

Sequential binary-to-BCD converter that turns the snake game's 8-bit `Length` count into three registered BCD digits for the seven-segment scan logic. It sits between the snake length/position block, which produces `Length`, and the SSD digit multiplexer, which consumes the digits. It replaces combinational divide/modulo with an 8-iteration shift-and-add-3 (double-dabble) engine. It re-converts automatically whenever `Length` changes, and also accepts an explicit start strobe.

---
 rtl/length_bcd_converter.sv | 127 ++++++++++++
 tb/tb_length_bcd_converter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/length_bcd_converter.sv
// length_bcd_converter: sequential double-dabble converter that turns the
// snake length count into three registered BCD digits for the SSD scan.
//
// Handshake: Start is a one-cycle request sampled only in IDLE (Busy=0);
// a Start seen while Busy=1 is dropped, never queued. Busy is high from the
// edge that accepts a conversion until the edge that publishes the digits,
// and Done pulses for exactly the one cycle after that publishing edge.
// With AUTO=1 a difference between Bin_In and the last converted value acts
// as an implicit Start whenever the block is idle.
module length_bcd_converter #(
  parameter int AUTO  = 1,
  parameter int BIN_W = 8
) (
  input  logic             board_clk,
  input  logic             Reset,
  input  logic [BIN_W-1:0] Bin_In,
  input  logic             Start,
  output logic [3:0]       Hundreds,
  output logic [3:0]       Tens,
  output logic [3:0]       Ones,
  output logic             Blank_H,
  output logic             Blank_T,
  output logic             Busy,
  output logic             Done,
  output logic             dbg_state
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WORK_W = 12 + BIN_W;

  state_t              state_q;
  state_t              state_d;
  logic [WORK_W-1:0]   work;
  logic [WORK_W-1:0]   adj;
  logic [WORK_W-1:0]   shifted;
  logic [2:0]          cnt;
  logic [BIN_W-1:0]    last_bin;
  logic                start_cond;

  // Start request: explicit strobe, or an unconverted new length in AUTO mode.
  always_comb begin
    start_cond = 1'b0;
    if (Start || ((AUTO != 0) && (Bin_In != last_bin))) begin
      start_cond = 1'b1;
    end
  end

  // Next-state logic: one load cycle, then exactly eight shift iterations.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_cond) state_d = SHIFT;
      SHIFT:   if (cnt == 3'd7) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble that is 5 or more, then shift left.
  always_comb begin
    adj = work;
    if (work[BIN_W+3:BIN_W] >= 4'd5) begin
      adj[BIN_W+3:BIN_W] = work[BIN_W+3:BIN_W] + 4'd3;
    end
    if (work[BIN_W+7:BIN_W+4] >= 4'd5) begin
      adj[BIN_W+7:BIN_W+4] = work[BIN_W+7:BIN_W+4] + 4'd3;
    end
    if (work[BIN_W+11:BIN_W+8] >= 4'd5) begin
      adj[BIN_W+11:BIN_W+8] = work[BIN_W+11:BIN_W+8] + 4'd3;
    end
    shifted = {adj[WORK_W-2:0], 1'b0};
  end

  // State register.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath: working register, counter, last value and published digits.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      work     <= '0;
      cnt      <= 3'd0;
      last_bin <= '0;
      Hundreds <= 4'd0;
      Tens     <= 4'd0;
      Ones     <= 4'd0;
      Blank_H  <= 1'b1;
      Blank_T  <= 1'b1;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_cond) begin
            work     <= {12'd0, Bin_In};
            last_bin <= Bin_In;
            cnt      <= 3'd0;
          end
        end
        SHIFT: begin
          work <= shifted;
          cnt  <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            // Digits only change here, so the display never sees partial sums.
            Hundreds <= shifted[BIN_W+11:BIN_W+8];
            Tens     <= shifted[BIN_W+7:BIN_W+4];
            Ones     <= shifted[BIN_W+3:BIN_W];
            Blank_H  <= (shifted[BIN_W+11:BIN_W+8] == 4'd0);
            Blank_T  <= (shifted[BIN_W+11:BIN_W+4] == 8'd0);
            Done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Busy and the debug state view come straight off the state flop.
  assign Busy      = (state_q == SHIFT);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_length_bcd_converter.sv
// Directed bench for length_bcd_converter: one AUTO=1 instance for the
// reset / blanking / mid-conversion scenarios, one AUTO=0 instance for the
// full 0..255 Start-driven sweep.
module tb_length_bcd_converter;

  // ---------------- clock / reset ----------------
  logic board_clk = 1'b0;
  logic Reset;
  always #5 board_clk = ~board_clk;

  // AUTO=1 instance
  logic [7:0] bin_a;
  logic       start_a;
  logic [3:0] a_h, a_t, a_o;
  logic       a_bh, a_bt, a_busy, a_done, a_dbg;

  // AUTO=0 instance
  logic [7:0] bin_m;
  logic       start_m;
  logic [3:0] m_h, m_t, m_o;
  logic       m_bh, m_bt, m_busy, m_done, m_dbg;

  length_bcd_converter #(.AUTO(1), .BIN_W(8)) dut_auto (
    .board_clk(board_clk), .Reset(Reset), .Bin_In(bin_a), .Start(start_a),
    .Hundreds(a_h), .Tens(a_t), .Ones(a_o), .Blank_H(a_bh), .Blank_T(a_bt),
    .Busy(a_busy), .Done(a_done), .dbg_state(a_dbg)
  );

  length_bcd_converter #(.AUTO(0), .BIN_W(8)) dut_man (
    .board_clk(board_clk), .Reset(Reset), .Bin_In(bin_m), .Start(start_m),
    .Hundreds(m_h), .Tens(m_t), .Ones(m_o), .Blank_H(m_bh), .Blank_T(m_bt),
    .Busy(m_busy), .Done(m_done), .dbg_state(m_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count edges until Done is seen at a negedge; bounded so it always returns.
  task automatic wait_done(input bit use_auto, output int cyc);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge board_clk);
      cyc++;
      @(negedge board_clk);
      if (use_auto ? a_done : m_done) break;
    end
  endtask

  function automatic logic [11:0] exp_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Drive a new value into the AUTO instance and wait for its conversion.
  task automatic conv_auto(input logic [7:0] v);
    int cyc;
    bin_a = v;
    @(posedge board_clk);
    @(negedge board_clk);
    check("auto_busy_rise", {15'd0, a_busy}, 16'd1);
    wait_done(1'b1, cyc);
    check("auto_latency", 16'(cyc), 16'd8);
    check("auto_digits", {4'd0, a_h, a_t, a_o}, {4'd0, exp_bcd(int'(v))});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int extra;
    Reset   = 1'b1;
    bin_a   = 8'd3;
    start_a = 1'b0;
    bin_m   = 8'd0;
    start_m = 1'b0;

    // Reset defaults with AUTO=1 and a nonzero input present.
    repeat (2) @(negedge board_clk);
    check("rst_digits", {4'd0, a_h, a_t, a_o}, 16'h0000);
    check("rst_blank", {14'd0, a_bh, a_bt}, 16'd3);
    check("rst_busy_done", {14'd0, a_busy, a_done}, 16'd0);
    check("rst_man_digits", {4'd0, m_h, m_t, m_o}, 16'h0000);

    Reset = 1'b0;
    @(posedge board_clk);
    @(negedge board_clk);
    check("post_rst_busy", {15'd0, a_busy}, 16'd1);
    wait_done(1'b1, cyc);
    check("post_rst_latency", 16'(cyc), 16'd8);
    check("post_rst_digits", {4'd0, a_h, a_t, a_o}, 16'h0003);
    check("post_rst_busy_fall", {15'd0, a_busy}, 16'd0);
    @(posedge board_clk);
    @(negedge board_clk);
    check("post_rst_done_1cyc", {15'd0, a_done}, 16'd0);

    // Blanking.
    conv_auto(8'd7);
    check("blank_7", {14'd0, a_bh, a_bt}, 16'd3);
    conv_auto(8'd42);
    check("blank_42", {14'd0, a_bh, a_bt}, 16'd2);
    conv_auto(8'd105);
    check("blank_105", {14'd0, a_bh, a_bt}, 16'd0);
    check("digits_105", {4'd0, a_h, a_t, a_o}, 16'h0105);

    // Mid-conversion change 10 -> 11, plus a Start pulse while busy.
    bin_a = 8'd10;
    @(posedge board_clk);                  // edge N
    @(negedge board_clk);
    check("mid_busy", {15'd0, a_busy}, 16'd1);
    repeat (3) @(posedge board_clk);       // edges N+1..N+3
    @(negedge board_clk);
    bin_a   = 8'd11;
    start_a = 1'b1;
    @(posedge board_clk);                  // edge N+4
    @(negedge board_clk);
    start_a = 1'b0;
    wait_done(1'b1, cyc);
    check("mid_first_latency", 16'(cyc), 16'd4);
    check("mid_first_digits", {4'd0, a_h, a_t, a_o}, 16'h0010);
    @(posedge board_clk);                  // edge N+9 restarts
    @(negedge board_clk);
    check("mid_restart_busy", {15'd0, a_busy}, 16'd1);
    check("mid_restart_nodone", {15'd0, a_done}, 16'd0);
    wait_done(1'b1, cyc);
    check("mid_second_latency", 16'(cyc), 16'd8);
    check("mid_second_digits", {4'd0, a_h, a_t, a_o}, 16'h0011);
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge board_clk);
      @(negedge board_clk);
      if (a_done || a_busy) extra++;
    end
    check("mid_no_extra_conv", 16'(extra), 16'd0);

    // Reset during SHIFT at Cnt=4.
    bin_a = 8'd200;
    @(posedge board_clk);                  // edge N, Cnt=0
    repeat (4) @(posedge board_clk);       // Cnt=4
    @(negedge board_clk);
    check("rs_in_shift", {15'd0, a_busy}, 16'd1);
    Reset = 1'b1;
    #1;
    check("rs_digits", {4'd0, a_h, a_t, a_o}, 16'h0000);
    check("rs_blank", {14'd0, a_bh, a_bt}, 16'd3);
    check("rs_busy_done", {14'd0, a_busy, a_done}, 16'd0);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge board_clk);
      if (a_done) extra++;
    end
    check("rs_no_done", 16'(extra), 16'd0);
    Reset = 1'b0;
    conv_auto(8'd200);
    check("blank_200", {14'd0, a_bh, a_bt}, 16'd0);

    // Start ignored while busy on the manual instance, no AUTO re-trigger.
    bin_m   = 8'd99;
    start_m = 1'b1;
    @(posedge board_clk);
    @(negedge board_clk);
    start_m = 1'b0;
    repeat (2) @(negedge board_clk);
    start_m = 1'b1;
    bin_m   = 8'd5;
    @(negedge board_clk);
    start_m = 1'b0;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge board_clk);
      @(negedge board_clk);
      if (m_done) extra++;
    end
    check("man_start_drop", 16'(extra), 16'd1);
    check("man_99", {4'd0, m_h, m_t, m_o}, 16'h0099);

    // Exhaustive Start-driven sweep.
    for (int v = 0; v < 256; v++) begin
      bin_m   = 8'(v);
      start_m = 1'b1;
      @(posedge board_clk);                // acceptance edge
      @(negedge board_clk);
      start_m = 1'b0;
      check("sweep_busy", {15'd0, m_busy}, 16'd1);
      wait_done(1'b0, cyc);
      check("sweep_latency", 16'(cyc), 16'd8);
      check("sweep_digits", {4'd0, m_h, m_t, m_o}, {4'd0, exp_bcd(v)});
      check("sweep_blank", {14'd0, m_bh, m_bt},
            {14'd0, (v < 100), (v < 10)});
      @(posedge board_clk);
      @(negedge board_clk);
      check("sweep_done_1cyc", {14'd0, m_done, m_busy}, 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
